// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA bus arbiter.
package dma_pkg;

    // Arbiter ownership states
    typedef enum logic [1:0] {
        CPU    = 2'd0,
        TURN_D = 2'd1,
        DMA    = 2'd2,
        TURN_C = 2'd3
    } state_e;

    // Transfer mode as presented by the DMAC
    typedef enum logic {
        MODE_BURST       = 1'b0,
        MODE_TRANSPARENT = 1'b1
    } mode_e;

    // BUS_OWNER encodings
    localparam logic [1:0] OWN_CPU  = 2'b00;
    localparam logic [1:0] OWN_DMA  = 2'b01;
    localparam logic [1:0] OWN_TURN = 2'b10;

    // Width needed to hold 0..maxBurst, never less than one bit
    function automatic int burstCountWidth(input int maxBurst);
        return (maxBurst < 1) ? 1 : $clog2(maxBurst + 1);
    endfunction

endpackage

// File: rtl/dma_bus_arbiter.sv
// Bus arbiter between the CPU and the DMAC: burst mode with a bounded burst
// length, transparent mode that hands idle CPU cycles to the DMAC, and a
// one-cycle turnaround on every ownership change. All outputs are registered.
module dma_bus_arbiter
    import dma_pkg::*;
#(
    parameter int MAX_BURST = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       HLD,
    input  logic       EOP,
    input  logic       MODE,
    input  logic       CPU_BREQ,
    input  logic       CPU_CYC,
    output logic       HLDA,
    output logic       BG,
    output logic       CPU_GNT,
    output logic [1:0] BUS_OWNER,
    output logic       PREEMPT
);

    localparam int             CW    = burstCountWidth(MAX_BURST);
    localparam logic [CW-1:0]  LIMIT = CW'((MAX_BURST > 0) ? (MAX_BURST - 1) : 0);

    state_e         r_state;
    mode_e          r_modeQ;
    logic           r_eopBlock;
    logic [CW-1:0]  r_count;

    state_e         w_nextState;
    mode_e          w_nextMode;
    logic           w_atLimit;
    logic           w_preempt;
    logic           w_eopExit;
    logic           w_stayDma;
    logic [CW-1:0]  w_nextCount;
    logic           w_nextEopBlock;
    logic           w_hldaNext;
    logic           w_bgNext;
    logic           w_gntNext;
    logic [1:0]     w_ownerNext;

    assign w_atLimit = (MAX_BURST != 0) && (r_count == LIMIT);

    // Next-state decision; EOP outranks HLD and the burst limit while in DMA
    always_comb begin
        w_nextState = r_state;
        w_nextMode  = r_modeQ;
        w_preempt   = 1'b0;
        w_eopExit   = 1'b0;
        case (r_state)
            CPU: begin
                if (HLD && !CPU_CYC && !r_eopBlock) begin
                    w_nextState = TURN_D;
                    w_nextMode  = mode_e'(MODE);
                end
            end
            TURN_D: begin
                w_nextState = HLD ? DMA : TURN_C;
            end
            DMA: begin
                if (EOP) begin
                    w_nextState = TURN_C;
                    w_eopExit   = 1'b1;
                end else if (!HLD) begin
                    w_nextState = TURN_C;
                end else if (r_modeQ == MODE_BURST && w_atLimit && CPU_BREQ) begin
                    w_nextState = TURN_C;
                    w_preempt   = 1'b1;
                end
            end
            TURN_C: begin
                w_nextState = CPU;
            end
            default: begin
                w_nextState = CPU;
            end
        endcase
    end

    // Burst counter restarts on every DMA entry and saturates at the limit so
    // an idle CPU lets the DMAC keep the bus; eop_block remembers a finished
    // transfer until the DMAC drops HLD
    always_comb begin
        w_stayDma = (r_state == DMA) && (w_nextState == DMA);
        if (!w_stayDma) begin
            w_nextCount = '0;
        end else if (w_atLimit) begin
            w_nextCount = r_count;
        end else begin
            w_nextCount = r_count + CW'(1);
        end

        if (!HLD) begin
            w_nextEopBlock = 1'b0;
        end else if (w_eopExit) begin
            w_nextEopBlock = 1'b1;
        end else begin
            w_nextEopBlock = r_eopBlock;
        end
    end

    // Output values for the cycle after the coming edge; in transparent mode
    // the grant follows the CPU request seen at that edge
    always_comb begin
        w_hldaNext  = 1'b0;
        w_bgNext    = 1'b0;
        w_gntNext   = 1'b0;
        w_ownerNext = OWN_TURN;
        case (w_nextState)
            CPU: begin
                w_gntNext   = 1'b1;
                w_ownerNext = OWN_CPU;
            end
            DMA: begin
                w_hldaNext = 1'b1;
                if (w_nextMode == MODE_TRANSPARENT && CPU_BREQ) begin
                    w_gntNext   = 1'b1;
                    w_ownerNext = OWN_CPU;
                end else begin
                    w_bgNext    = 1'b1;
                    w_ownerNext = OWN_DMA;
                end
            end
            default: begin
                w_ownerNext = OWN_TURN;
            end
        endcase
    end

    // State and registered outputs; reset drops HLDA immediately, no turnaround
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= CPU;
            r_modeQ    <= MODE_BURST;
            r_eopBlock <= 1'b0;
            r_count    <= '0;
            HLDA       <= 1'b0;
            BG         <= 1'b0;
            CPU_GNT    <= 1'b1;
            BUS_OWNER  <= OWN_CPU;
            PREEMPT    <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_modeQ    <= w_nextMode;
            r_eopBlock <= w_nextEopBlock;
            r_count    <= w_nextCount;
            HLDA       <= w_hldaNext;
            BG         <= w_bgNext;
            CPU_GNT    <= w_gntNext;
            BUS_OWNER  <= w_ownerNext;
            PREEMPT    <= w_preempt;
        end
    end

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Scoreboard bench for dma_bus_arbiter: a stimulus process drives inputs on
// the falling edge and queues the expected outputs from a behavioural model;
// a monitor process checks the DUT a little after each rising edge.
module tb_dma_bus_arbiter;

    localparam int MAX_BURST = 4;

    typedef struct packed {
        logic       hlda;
        logic       bg;
        logic       gnt;
        logic [1:0] owner;
        logic       preempt;
    } expect_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       HLD = 1'b0;
    logic       EOP = 1'b0;
    logic       MODE = 1'b0;
    logic       CPU_BREQ = 1'b0;
    logic       CPU_CYC = 1'b0;
    logic       HLDA;
    logic       BG;
    logic       CPU_GNT;
    logic [1:0] BUS_OWNER;
    logic       PREEMPT;

    int testsRun = 0;
    int testsFailed = 0;
    expect_t expQ[$];

    // Model state: who holds the bus and how long the DMAC has held it
    localparam int HOLDER_CPU      = 0;
    localparam int HOLDER_TO_DMA   = 1;
    localparam int HOLDER_DMA      = 2;
    localparam int HOLDER_TO_CPU   = 3;
    int   holder = HOLDER_CPU;
    int   dmaCyclesHeld = 0;
    bit   transparent = 1'b0;
    bit   finishedTransfer = 1'b0;

    dma_bus_arbiter #(.MAX_BURST(MAX_BURST)) dut (
        .CLK(CLK),
        .RST(RST),
        .HLD(HLD),
        .EOP(EOP),
        .MODE(MODE),
        .CPU_BREQ(CPU_BREQ),
        .CPU_CYC(CPU_CYC),
        .HLDA(HLDA),
        .BG(BG),
        .CPU_GNT(CPU_GNT),
        .BUS_OWNER(BUS_OWNER),
        .PREEMPT(PREEMPT)
    );

    always #5 CLK = ~CLK;

    // Advance the model by one rising edge and return the outputs it implies
    function automatic expect_t modelStep(bit rst, bit hld, bit eop, bit mode, bit breq, bit cyc);
        expect_t e;
        bit endedByEop = 1'b0;
        bit forced = 1'b0;
        if (rst) begin
            holder = HOLDER_CPU;
            dmaCyclesHeld = 0;
            transparent = 1'b0;
            finishedTransfer = 1'b0;
        end else begin
            if (holder == HOLDER_CPU) begin
                if (hld && !cyc && !finishedTransfer) begin
                    holder = HOLDER_TO_DMA;
                    transparent = mode;
                end
            end else if (holder == HOLDER_TO_DMA) begin
                if (hld) begin
                    holder = HOLDER_DMA;
                    dmaCyclesHeld = 1;
                end else begin
                    holder = HOLDER_TO_CPU;
                end
            end else if (holder == HOLDER_DMA) begin
                if (eop) begin
                    endedByEop = 1'b1;
                    holder = HOLDER_TO_CPU;
                end else if (!hld) begin
                    holder = HOLDER_TO_CPU;
                end else if (!transparent && MAX_BURST > 0 && breq && dmaCyclesHeld >= MAX_BURST) begin
                    forced = 1'b1;
                    holder = HOLDER_TO_CPU;
                end else begin
                    dmaCyclesHeld++;
                end
            end else begin
                holder = HOLDER_CPU;
            end
            if (!hld) finishedTransfer = 1'b0;
            else if (endedByEop) finishedTransfer = 1'b1;
        end

        e.preempt = forced;
        e.hlda = (holder == HOLDER_DMA);
        if (holder == HOLDER_CPU || (holder == HOLDER_DMA && transparent && breq)) begin
            e.gnt = 1'b1; e.bg = 1'b0; e.owner = 2'b00;
        end else if (holder == HOLDER_DMA) begin
            e.gnt = 1'b0; e.bg = 1'b1; e.owner = 2'b01;
        end else begin
            e.gnt = 1'b0; e.bg = 1'b0; e.owner = 2'b10;
        end
        return e;
    endfunction

    // Drive one cycle of inputs and queue what the DUT must show after the edge
    task automatic applyStimulus(bit rst, bit hld, bit eop, bit mode, bit breq, bit cyc);
        @(negedge CLK);
        RST = rst; HLD = hld; EOP = eop; MODE = mode; CPU_BREQ = breq; CPU_CYC = cyc;
        expQ.push_back(modelStep(rst, hld, eop, mode, breq, cyc));
    endtask

    task automatic checkOutput(string name, logic [1:0] actual, logic [1:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s at %0t: got %b, expected %b", name, $time, actual, expected);
        end
    endtask

    // Monitor: every cycle the DUT presents a full output set; compare it
    initial begin
        expect_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("HLDA", {1'b0, HLDA}, {1'b0, e.hlda});
                checkOutput("BG", {1'b0, BG}, {1'b0, e.bg});
                checkOutput("CPU_GNT", {1'b0, CPU_GNT}, {1'b0, e.gnt});
                checkOutput("BUS_OWNER", BUS_OWNER, e.owner);
                checkOutput("PREEMPT", {1'b0, PREEMPT}, {1'b0, e.preempt});
                checkOutput("one_owner", 2'(int'(CPU_GNT) + int'(BG) + int'(BUS_OWNER == 2'b10)), 2'd1);
            end
        end
    end

    // Stimulus: directed scenarios first, then a long randomized run
    initial begin
        bit r, h, ep, m, b, c;
        // reset for two cycles
        repeat (2) applyStimulus(1, 0, 0, 0, 0, 0);
        // burst grant, EOP, HLD held so no re-grant, then HLD low, re-grant
        repeat (6) applyStimulus(0, 1, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 0, 0, 0);
        repeat (4) applyStimulus(0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        repeat (4) applyStimulus(0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        repeat (2) applyStimulus(0, 0, 0, 0, 0, 0);
        // burst limit with CPU requesting throughout
        repeat (16) applyStimulus(0, 1, 0, 0, 1, 0);
        // idle CPU at the limit: the DMAC keeps the bus, then the CPU asks
        repeat (3) applyStimulus(0, 0, 0, 0, 0, 0);
        repeat (8) applyStimulus(0, 1, 0, 0, 0, 0);
        repeat (3) applyStimulus(0, 1, 0, 0, 1, 0);
        // EOP coincides with the limit: EOP wins, no preempt
        repeat (3) applyStimulus(0, 0, 0, 0, 0, 0);
        repeat (5) applyStimulus(0, 1, 0, 0, 1, 0);
        applyStimulus(0, 1, 1, 0, 1, 0);
        repeat (3) applyStimulus(0, 0, 0, 0, 0, 0);
        // transparent mode with a request pattern, MODE toggled mid-transfer
        repeat (2) applyStimulus(0, 1, 0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 1, 0);
        applyStimulus(0, 1, 0, 1, 1, 0);
        applyStimulus(0, 1, 0, 0, 0, 0);
        repeat (6) applyStimulus(0, 1, 0, 0, 1, 0);
        repeat (3) applyStimulus(0, 0, 0, 0, 0, 0);
        // grant blocked by a CPU cycle in progress
        repeat (3) applyStimulus(0, 1, 0, 0, 0, 1);
        repeat (3) applyStimulus(0, 1, 0, 0, 0, 0);
        // reset in the middle of a transfer
        applyStimulus(1, 1, 0, 0, 0, 0);
        repeat (3) applyStimulus(0, 1, 0, 0, 0, 0);
        repeat (2) applyStimulus(0, 0, 0, 0, 0, 0);
        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            r  = ($urandom_range(99, 0) < 2);
            h  = ($urandom_range(99, 0) < 85);
            ep = ($urandom_range(99, 0) < 8);
            m  = ($urandom_range(99, 0) < 50);
            b  = ($urandom_range(99, 0) < 50);
            c  = ($urandom_range(99, 0) < 20);
            applyStimulus(r, h, ep, m, b, c);
        end
        @(negedge CLK);
        EOP = 1'b0; HLD = 1'b0;
        for (int k = 0; k < 10 && expQ.size() > 0; k++) @(negedge CLK);
        testsRun++;
        if (expQ.size() != 0) begin
            testsFailed++;
            $display("[TB] FAIL drain: got %0d pending, expected 0", expQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
